// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and helpers for the multi-cycle ALU.
// Encodings are compatible with the single-cycle datapath ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MUL   = 4'b1000;
  localparam logic [3:0] ALU_MULHU = 4'b1001;
  localparam logic [3:0] ALU_DIVU  = 4'b1010;
  localparam logic [3:0] ALU_REMU  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic is_iterative(
    input logic [3:0] op
  );
    return op inside {ALU_MUL, ALU_MULHU,
                      ALU_DIVU, ALU_REMU};
  endfunction

  function automatic logic is_div(
    input logic [3:0] op
  );
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared radix-2 shift-add multiplier / restoring divider.
// hi/lo present the accumulator after the current step.
module alu_muldiv_iter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);
  import alu_pkg::*;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] nxt;
  logic [WIDTH-1:0]   m;
  logic               md;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     top;
  logic [WIDTH:0]     diff;

  // one iteration: add-and-shift-right (mul) or
  // shift-left-and-trial-subtract (div, mode=1)
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, m};
    top  = acc[2*WIDTH-1:WIDTH-1];
    diff = top - {1'b0, m};
    nxt  = acc;
    if (md) begin
      if (!diff[WIDTH])
        nxt = {diff[WIDTH-1:0],
               acc[WIDTH-2:0], 1'b1};
      else
        nxt = {acc[2*WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      nxt = {sum, acc[WIDTH-1:1]};
    end else begin
      nxt = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  assign hi   = nxt[2*WIDTH-1:WIDTH];
  assign lo   = nxt[WIDTH-1:0];
  assign last = (cnt == CNT_W'(WIDTH - 1));

  // load operands, then step until the counter reaches WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      m   <= '0;
      md  <= 1'b0;
      cnt <= CNT_W'(WIDTH);
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, (mode ? a : b)};
      m   <= mode ? b : a;
      md  <= mode;
      cnt <= '0;
    end else if (cnt != CNT_W'(WIDTH)) begin
      acc <= nxt;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle execute-stage ALU with start/done handshake.
// Simple ops finish next cycle; mul/div iterate WIDTH times.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero,
  output logic             divByZero
);

  state_t           state;
  logic [3:0]       op_q;
  logic             dz;
  logic             load;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             last;
  logic [WIDTH-1:0] it_res;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] s_res;
  logic             s_c;
  logic             s_v;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c;
  logic             fin_v;
  logic             fin_dz;

  assign ready = (state == IDLE);
  assign busy  = ~ready;
  assign dz    = is_div(ALUControl) && (b == '0);
  assign load  = ready && start &&
                 is_iterative(ALUControl) && !dz;

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .mode  (is_div(ALUControl)),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .last  (last)
  );

  assign it_res = (op_q == ALU_MULHU ||
                   op_q == ALU_REMU) ? hi : lo;

  // single-cycle ops straight from the live operands
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = a - b;
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    unique case (1'b1)
      (ALUControl == ALU_AND): s_res = a & b;
      (ALUControl == ALU_OR):  s_res = a | b;
      (ALUControl == ALU_NOR): s_res = ~(a | b);
      (ALUControl == ALU_ADD): begin
        s_res = sum[WIDTH-1:0];
        s_c   = sum[WIDTH];
        s_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                (sum[WIDTH-1] != a[WIDTH-1]);
      end
      (ALUControl == ALU_SUB): begin
        s_res = dif;
        s_c   = (a < b);
        s_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                (dif[WIDTH-1] != a[WIDTH-1]);
      end
      (ALUControl == ALU_SLTU):
        s_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: ;
    endcase
  end

  // divide-by-zero skips iteration and finishes directly
  always_comb begin
    fin_res = s_res;
    fin_c   = s_c;
    fin_v   = s_v;
    fin_dz  = 1'b0;
    if (dz) begin
      fin_res = (ALUControl == ALU_DIVU) ? '1 : a;
      fin_c   = 1'b0;
      fin_v   = 1'b0;
      fin_dz  = 1'b1;
    end
  end

  // control FSM and registered result/flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= ALU_AND;
      result    <= '0;
      carryOut  <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          op_q <= ALUControl;
          if (load) begin
            state <= ITER;
          end else begin
            state     <= FIN;
            done      <= 1'b1;
            result    <= fin_res;
            carryOut  <= fin_c;
            overflow  <= fin_v;
            zero      <= (fin_res == '0);
            divByZero <= fin_dz;
          end
        end
        ITER: if (last) begin
          state     <= FIN;
          done      <= 1'b1;
          result    <= it_res;
          carryOut  <= 1'b0;
          overflow  <= 1'b0;
          zero      <= (it_res == '0);
          divByZero <= 1'b0;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed 64-bit cases plus
// randomized 8-bit and 64-bit sweeps against a model.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start64 = 1'b0;
  logic        start8 = 1'b0;
  logic [3:0]  op = 4'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        sel = 1'b0;

  logic        ready64, busy64, done64;
  logic [63:0] res64;
  logic        c64, v64, z64, dz64;
  logic        ready8, busy8, done8;
  logic [7:0]  res8;
  logic        c8, v8, z8, dz8;

  int nasrt = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(64)) u64 (
    .clk(clk), .rst_n(rst_n), .start(start64),
    .a(a), .b(b), .ALUControl(op),
    .ready(ready64), .busy(busy64), .done(done64),
    .result(res64), .carryOut(c64),
    .overflow(v64), .zero(z64), .divByZero(dz64)
  );

  alu_multicycle #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a(a[7:0]), .b(b[7:0]), .ALUControl(op),
    .ready(ready8), .busy(busy8), .done(done8),
    .result(res8), .carryOut(c8),
    .overflow(v8), .zero(z8), .divByZero(dz8)
  );

  wire        ready_s = sel ? ready8 : ready64;
  wire        busy_s  = sel ? busy8  : busy64;
  wire        done_s  = sel ? done8  : done64;
  wire [63:0] res_s   = sel ? {56'b0, res8} : res64;
  wire        c_s     = sel ? c8  : c64;
  wire        v_s     = sel ? v8  : v64;
  wire        z_s     = sel ? z8  : z64;
  wire        dz_s    = sel ? dz8 : dz64;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    nasrt++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  // spec-level reference using wide integer arithmetic
  function automatic void model(
    input  int          w,
    input  logic [3:0]  o,
    input  logic [63:0] x,
    input  logic [63:0] y,
    output logic [63:0] r,
    output logic        c,
    output logic        v,
    output logic        dzo,
    output int          lat
  );
    logic [127:0] mask, xx, yy, p;
    logic signed [127:0] sx, sy, t, lim;
    mask = (128'd1 << w) - 128'd1;
    xx   = {64'd0, x} & mask;
    yy   = {64'd0, y} & mask;
    sx   = $signed(xx);
    sy   = $signed(yy);
    if (xx[w-1]) sx = sx - $signed(mask) - 128'sd1;
    if (yy[w-1]) sy = sy - $signed(mask) - 128'sd1;
    lim  = $signed(128'd1 << (w - 1));
    c = 1'b0; v = 1'b0; dzo = 1'b0; lat = 1;
    p = '0;
    case (o)
      ALU_AND: p = xx & yy;
      ALU_OR:  p = xx | yy;
      ALU_NOR: p = ~(xx | yy);
      ALU_ADD: begin
        p = xx + yy;
        c = ((p >> w) != 0);
        t = sx + sy;
        v = (t >= lim) || (t < -lim);
      end
      ALU_SUB: begin
        p = xx - yy;
        c = (xx < yy);
        t = sx - sy;
        v = (t >= lim) || (t < -lim);
      end
      ALU_SLTU: p = {127'd0, (xx < yy)};
      ALU_MUL: begin
        p = xx * yy; lat = w + 1;
      end
      ALU_MULHU: begin
        p = (xx * yy) >> w; lat = w + 1;
      end
      ALU_DIVU: begin
        if (yy == 0) begin p = mask; dzo = 1'b1; end
        else begin p = xx / yy; lat = w + 1; end
      end
      ALU_REMU: begin
        if (yy == 0) begin p = xx; dzo = 1'b1; end
        else begin p = xx % yy; lat = w + 1; end
      end
      default: p = '0;
    endcase
    p = p & mask;
    r = p[63:0];
  endfunction

  task automatic issue(input logic s,
                       input logic [3:0] o,
                       input logic [63:0] x,
                       input logic [63:0] y);
    logic [63:0] er;
    logic ec, ev, edz;
    int el, lat, w;
    string t;
    w = s ? 8 : 64;
    t = $sformatf("w%0d op%b", w, o);
    model(w, o, x, y, er, ec, ev, edz, el);
    @(negedge clk);
    sel = s;
    check({t, " ready"}, 64'(ready_s), 64'd1);
    op = o; a = x; b = y;
    if (s) start8 = 1'b1;
    else   start64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; start64 = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    op = 4'($urandom);
    lat = 1;
    while (!done_s && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({t, " latency"}, 64'(lat), 64'(el));
    check({t, " result"}, res_s, er);
    check({t, " carry"}, 64'(c_s), 64'(ec));
    check({t, " ovf"}, 64'(v_s), 64'(ev));
    check({t, " zero"}, 64'(z_s), 64'(er == '0));
    check({t, " dbz"}, 64'(dz_s), 64'(edz));
    check({t, " busy"}, 64'(busy_s), 64'd1);
    @(negedge clk);
    check({t, " pulse"}, 64'(done_s), 64'd0);
    check({t, " idle"}, 64'(ready_s), 64'd1);
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic [3:0] ops [11];
  int nd, t1, t2;
  logic [63:0] r1, r2, x, y;

  initial begin
    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
            ALU_SLTU, ALU_NOR, ALU_MUL, ALU_MULHU,
            ALU_DIVU, ALU_REMU, 4'b0101};

    // reset values
    repeat (2) @(negedge clk);
    check("rst result", res64, 64'd0);
    check("rst flags", {60'd0, c64, v64, z64, dz64},
          64'd0);
    check("rst done", 64'(done64), 64'd0);
    check("rst ready", 64'(ready64), 64'd1);
    check("rst busy", 64'(busy64), 64'd0);
    rst_n = 1'b1;

    // abort a MUL with reset mid-flight
    @(negedge clk);
    sel = 1'b0;
    op = ALU_MUL; a = 64'd3; b = 64'd5;
    start64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start64 = 1'b0;
    nd = 0;
    repeat (9) begin
      if (done64) nd++;
      @(negedge clk);
    end
    check("midop busy", 64'(busy64), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort result", res64, 64'd0);
    check("abort flags", {60'd0, c64, v64, z64, dz64},
          64'd0);
    check("abort done", 64'(done64), 64'd0);
    check("abort ready", 64'(ready64), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (done64) nd++;
    end
    check("abort no done", 64'(nd), 64'd0);
    issue(1'b0, ALU_MUL, 64'd3, 64'd5);
    check("reissue mul", res64, 64'd15);

    // directed 64-bit cases
    issue(1'b0, ALU_ADD, ONES, 64'd1);
    check("add wrap", res64, 64'd0);
    check("add wrap c", 64'(c64), 64'd1);
    issue(1'b0, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    check("add ovf", 64'(v64), 64'd1);
    issue(1'b0, ALU_SUB, 64'd2, 64'd5);
    check("sub", res64, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(1'b0, ALU_SLTU, 64'd2, 64'd5);
    check("sltu", res64, 64'd1);
    issue(1'b0, ALU_MULHU, ONES, ONES);
    check("mulhu", res64, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(1'b0, ALU_MUL, ONES, ONES);
    check("mul", res64, 64'd1);
    issue(1'b0, ALU_DIVU, 64'd100, 64'd7);
    check("divu", res64, 64'd14);
    issue(1'b0, ALU_REMU, 64'd100, 64'd7);
    check("remu", res64, 64'd2);
    issue(1'b0, ALU_DIVU, 64'd9, 64'd0);
    check("div0", res64, ONES);
    check("div0 flag", 64'(dz64), 64'd1);
    issue(1'b0, ALU_REMU, 64'd0, 64'd0);
    issue(1'b0, ALU_NOR, 64'h0F0F, 64'hF000);
    issue(1'b0, 4'b0011, 64'd7, 64'd9);

    // start held high through a DIVU
    @(negedge clk);
    sel = 1'b0;
    op = ALU_DIVU; a = 64'd100; b = 64'd7;
    start64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = ALU_ADD; a = 64'd1; b = 64'd2;
    nd = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0;
    for (int k = 1; k <= 72; k++) begin
      if (done64) begin
        nd++;
        if (nd == 1) begin t1 = k; r1 = res64; end
        if (nd == 2) begin t2 = k; r2 = res64; end
      end
      if (k == 67) start64 = 1'b0;
      @(negedge clk);
    end
    check("held dones", 64'(nd), 64'd2);
    check("held t1", 64'(t1), 64'd65);
    check("held r1", r1, 64'd14);
    check("held t2", 64'(t2), 64'd67);
    check("held r2", r2, 64'd3);

    // random sweep at WIDTH=8
    for (int i = 0; i < 150; i++) begin
      x = 64'($urandom_range(0, 255));
      y = ($urandom_range(0, 7) == 0) ? 64'd0 :
          64'($urandom_range(0, 255));
      issue(1'b1, ops[$urandom_range(0, 10)], x, y);
    end

    // a few random 64-bit ops
    for (int i = 0; i < 12; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      issue(1'b0, ops[$urandom_range(0, 10)], x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised successor to the single-cycle datapath ALU. It keeps the existing 4-bit ALUControl encodings and adds iterative multiply and divide. All results are registered and returned through a start/done handshake. It sits in the execute stage of the multi-cycle processor variant; the control FSM stalls on busy.

Parameters:
WIDTH, 64, operand/result width in bits (legal: 8..64, even)
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
ALUControl  input  4  operation, captured on accepted start
ready  output  1  block idle; a start will be accepted
busy  output  1  operation in flight (equals ~ready)
done  output  1  one-cycle pulse; result/flags valid from this cycle until next accepted start
result  output  WIDTH  registered result
carryOut  output  1  ADD: carry out; SUB: borrow (1 when a<b unsigned); else 0
overflow  output  1  signed overflow for ADD/SUB; else 0
zero  output  1  result == 0
divByZero  output  1  set with done when DIVU/REMU and b==0

Behaviour:
- Opcodes (alu_pkg): 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLTU (result = {WIDTH-1 zeros, a<b unsigned}), 1100 NOR, 1000 MUL (low WIDTH bits of unsigned product), 1001 MULHU (high WIDTH bits), 1010 DIVU, 1011 REMU. Any other code: result 0, zero 1, single-cycle.
- Reset (async assert, sync deassert handled upstream): state IDLE; result, carryOut, overflow, zero, done, divByZero = 0; ready=1. Assertion mid-operation aborts the operation with no done pulse.
- FSM: IDLE -> (start & simple op) -> FIN; IDLE -> (start & MUL/MULHU/DIVU/REMU) -> ITER; ITER -> FIN when counter reaches WIDTH; FIN -> IDLE.
- FIN lasts one cycle: outputs are registered and done=1. ready is 0 in ITER and FIN, 1 in IDLE.
- Latency: simple op accepted at edge N -> done high in cycle N+1. Mul/div accepted at N -> done at N+WIDTH+1.
- Back-to-back: start is accepted in the IDLE cycle after FIN, so throughput for simple ops is one op per 2 cycles. start while busy is ignored (not queued).
- MUL: radix-2 shift-add over WIDTH iterations into a 2*WIDTH accumulator. MUL takes the low half, MULHU the high half.
- DIVU/REMU: restoring division, WIDTH iterations. With b==0 there are no iterations: the op goes straight to FIN; quotient = all ones, remainder = a, divByZero=1.
- Operands are held in internal registers; a/b/ALUControl may change freely after acceptance.
- zero is computed from the final registered result. Flags hold until the next done.

Decomposition:
- alu_pkg: opcode localparams (ALU_AND..ALU_REMU), FSM state encoding (IDLE, ITER, FIN), helper function is_iterative(op).
- Sub-module alu_muldiv_iter: shared shift/accumulate datapath with a 2*WIDTH register and counter. Inputs: load, mode (mul/div), a, b. Outputs: hi, lo, last.
- The top level holds the FSM, the combinational simple-op unit and the output registers.

Test Plan:
- Reset mid-MUL (WIDTH=64, a=3, b=5, pull rst_n low at cycle 10) -> outputs all 0, ready=1, no done. A re-issued MUL completes at start+65 with result 15.
- ADD a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> done at N+1, result 0, carryOut 1, zero 1, overflow 0. ADD 64'h7FFF_FFFF_FFFF_FFFF + 1 -> overflow 1, carryOut 0.
- SUB a=2, b=5 -> result 64'hFFFF_FFFF_FFFF_FFFD, carryOut 1. SLTU a=2, b=5 -> result 1.
- MULHU a=b=64'hFFFF_FFFF_FFFF_FFFF -> result 64'hFFFF_FFFF_FFFF_FFFE, done at N+65. MUL with the same operands -> result 1.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 9/0 -> result all ones, divByZero 1, done at N+1.
- start held high during a DIVU -> only one done pulse for that op; the next op is accepted in the IDLE cycle after FIN. Random sweep at WIDTH=8 over all opcodes versus a reference model.
